apb_uart_sched: RTL

Two-requester APB master that shares the single APB UART slave (TX/RX data and config registers) between requesters, e.g. a CPU-side port and a DMA/loopback engine.
- Accepts one transaction at a time from a requester, arbitrating round-robin.
- Drives a compliant APB SETUP/ACCESS sequence and honours PREADY wait states.
- Returns PRDATA/PSLVERR to the granted requester.
- Sits directly in front of apb_uart_top.

---
 rtl/apb_uart_sched_pkg.sv | 9 +
 rtl/apb_uart_rr_arb.sv | 37 +++
 rtl/apb_uart_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apb_uart_sched_pkg.sv
// apb_uart_sched_pkg: shared state type and constants for the APB UART scheduler.
package apb_uart_sched_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} sched_state_t;

    localparam int unsigned NUM_REQ         = 2;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/apb_uart_rr_arb.sv
// apb_uart_rr_arb: two-way round-robin arbiter; on a tie, the requester not served last wins.
module apb_uart_rr_arb
    import apb_uart_sched_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               last_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (advance_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    // last_q = 1 after reset so a tie goes to requester 0 first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/apb_uart_sched.sv
// apb_uart_sched: round-robin two-requester APB master sharing one APB UART slave.
// Define APB_UART_SCHED_TIMEOUT_EN to abandon ACCESS after TIMEOUT cycles without PREADY.
module apb_uart_sched
    import apb_uart_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSELx,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    sched_state_t          state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gsel;
    logic                  timeout_hit;
    logic                  unused_last;

    apb_uart_rr_arb u_arb (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .req_i     (req_valid),
        .advance_i (state_q == IDLE),
        .gnt_o     (gnt),
        .last_o    (unused_last)
    );

    assign gsel = gnt[1];

`ifdef APB_UART_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ACCESS) && !PREADY) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires on the ACCESS cycle whose stall would bring the count to TIMEOUT
    assign timeout_hit = (state_q == ACCESS) && !PREADY && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = gnt;
                    owner_d   = gsel;
                    pwrite_d  = req_write[gsel];
                    paddr_d   = gsel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                     : req_addr[ADDR_WIDTH-1:0];
                    pwdata_d  = gsel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : req_wdata[DATA_WIDTH-1:0];
                    state_d   = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign PSELx     = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) && err_q;

    // Requesters must hold valid and payload until accepted
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        a_req_hold: assert property (@(posedge PCLK) disable iff (PRESET)
            (req_valid[i] && !req_ready[i]) |=>
                (req_valid[i] && $stable(req_write[i])
                 && $stable(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
                 && $stable(req_wdata[i*DATA_WIDTH +: DATA_WIDTH])));
    end

endmodule
